// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Request/grant handshake, then a separate read-data-valid response.
interface lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu.sv
// Memory-stage load/store unit: one decoded load/store becomes one bus transaction,
// with lane steering, load extension, misalign detection and a bus timeout.
module lsu #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mtype_i,
    input  logic        ex_mem_rw_i,
    input  logic [1:0]  ex_mem_width_i,
    input  logic        ex_mem_rdtype_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    lsu_if.master       dm,
    output logic        lsu_stall_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_misalign_o,
    output logic        lsu_err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic [1:0]       width_q, width_d;
    logic             rdtype_q, rdtype_d;
    logic [1:0]       off_q, off_d;
    logic [29:0]      waddr_q, waddr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             req_q, req_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             misalign_q, misalign_d;
    logic             err_q, err_d;

    logic             aligned_c;
    logic             start_c;
    logic             last_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [31:0]      ext_c;

    // Alignment and start qualification
    always_comb begin
        aligned_c = 1'b0;
        case (ex_mem_width_i)
            2'd0:    aligned_c = 1'b1;
            2'd1:    aligned_c = ~ex_addr_i[0];
            2'd2:    aligned_c = (ex_addr_i[1:0] == 2'b00);
            default: aligned_c = 1'b0;
        endcase
    end

    assign start_c     = (state_q == S_IDLE) && ex_mtype_i && aligned_c;
    assign last_c      = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign lsu_stall_o = start_c || (state_q == S_REQ) || (state_q == S_WAIT_R);

    // Store lane steering: byte enables and replicated write data
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = ex_wdata_i;
        case (ex_mem_width_i)
            2'd0: begin
                be_c    = 4'b0001 << ex_addr_i[1:0];
                wdata_c = {4{ex_wdata_i[7:0]}};
            end
            2'd1: begin
                be_c    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ex_wdata_i[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = ex_wdata_i;
            end
        endcase
    end

    // Load lane extraction and extension, using the offset latched at start
    always_comb begin
        byte_c = dm.rdata[7:0];
        case (off_q)
            2'd0:    byte_c = dm.rdata[7:0];
            2'd1:    byte_c = dm.rdata[15:8];
            2'd2:    byte_c = dm.rdata[23:16];
            default: byte_c = dm.rdata[31:24];
        endcase
        half_c = off_q[1] ? dm.rdata[31:16] : dm.rdata[15:0];
        case (width_q)
            2'd0:    ext_c = rdtype_q ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
            2'd1:    ext_c = rdtype_q ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
            default: ext_c = dm.rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        width_d    = width_q;
        rdtype_d   = rdtype_q;
        off_d      = off_q;
        waddr_d    = waddr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        req_d      = 1'b0;
        rvalid_d   = 1'b0;
        misalign_d = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d  = S_REQ;
                    cnt_d    = '0;
                    rw_d     = ex_mem_rw_i;
                    width_d  = ex_mem_width_i;
                    rdtype_d = ex_mem_rdtype_i;
                    off_d    = ex_addr_i[1:0];
                    waddr_d  = ex_addr_i[31:2];
                    be_d     = be_c;
                    wdata_d  = wdata_c;
                    req_d    = 1'b1;
                end else if (ex_mtype_i) begin
                    state_d    = S_DONE;
                    misalign_d = 1'b1;
                end
            end
            S_REQ: begin
                if (dm.gnt) begin
                    state_d = rw_q ? S_WAIT_R : S_DONE;
                    cnt_d   = '0;
                end else if (last_c) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    req_d = 1'b1;
                end
            end
            S_WAIT_R: begin
                if (dm.rvalid) begin
                    state_d  = S_DONE;
                    rvalid_d = 1'b1;
                    rdata_d  = ext_c;
                end else if (last_c) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            width_q    <= 2'd0;
            rdtype_q   <= 1'b0;
            off_q      <= 2'd0;
            waddr_q    <= 30'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            req_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            width_q    <= width_d;
            rdtype_q   <= rdtype_d;
            off_q      <= off_d;
            waddr_q    <= waddr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            req_q      <= req_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
        end
    end

    assign dm.req         = req_q;
    assign dm.we          = ~rw_q;
    assign dm.addr        = {waddr_q, 2'b00};
    assign dm.be          = be_q;
    assign dm.wdata       = wdata_q;
    assign lsu_rvalid_o   = rvalid_q;
    assign lsu_rdata_o    = rdata_q;
    assign lsu_misalign_o = misalign_q;
    assign lsu_err_o      = err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, misaligned accesses, bus timeout
// and reset in the middle of a load.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        ex_mtype_i;
    logic        ex_mem_rw_i;
    logic [1:0]  ex_mem_width_i;
    logic        ex_mem_rdtype_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_stall_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_misalign_o;
    logic        lsu_err_o;

    int n_chk;
    int n_err;

    lsu_if dm_bus ();

    lsu #(.TIMEOUT_CYC(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_mtype_i      (ex_mtype_i),
        .ex_mem_rw_i     (ex_mem_rw_i),
        .ex_mem_width_i  (ex_mem_width_i),
        .ex_mem_rdtype_i (ex_mem_rdtype_i),
        .ex_addr_i       (ex_addr_i),
        .ex_wdata_i      (ex_wdata_i),
        .dm              (dm_bus),
        .lsu_stall_o     (lsu_stall_o),
        .lsu_rvalid_o    (lsu_rvalid_o),
        .lsu_rdata_o     (lsu_rdata_o),
        .lsu_misalign_o  (lsu_misalign_o),
        .lsu_err_o       (lsu_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle; registered outputs are settled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic rw, input logic [1:0] width, input logic rdtype,
                           input logic [31:0] addr, input logic [31:0] wdata);
        ex_mtype_i      = 1'b1;
        ex_mem_rw_i     = rw;
        ex_mem_width_i  = width;
        ex_mem_rdtype_i = rdtype;
        ex_addr_i       = addr;
        ex_wdata_i      = wdata;
    endtask

    // Load with gnt in the first REQ cycle and rvalid the cycle after.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] width,
                            input logic rdtype, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_res);
        present(1'b1, width, rdtype, addr, 32'h0);
        #1;
        chk({tag, " c0 stall"}, 32'(lsu_stall_o), 32'd1);
        chk({tag, " c0 req"}, 32'(dm_bus.req), 32'd0);
        tick();
        chk({tag, " c1 req"}, 32'(dm_bus.req), 32'd1);
        chk({tag, " c1 addr"}, dm_bus.addr, exp_addr);
        chk({tag, " c1 be"}, 32'(dm_bus.be), 32'(exp_be));
        chk({tag, " c1 we"}, 32'(dm_bus.we), 32'd0);
        chk({tag, " c1 stall"}, 32'(lsu_stall_o), 32'd1);
        dm_bus.gnt = 1'b1;
        tick();
        dm_bus.gnt = 1'b0;
        chk({tag, " c2 req"}, 32'(dm_bus.req), 32'd0);
        chk({tag, " c2 stall"}, 32'(lsu_stall_o), 32'd1);
        dm_bus.rvalid = 1'b1;
        dm_bus.rdata  = rdata;
        tick();
        dm_bus.rvalid = 1'b0;
        dm_bus.rdata  = 32'h0;
        chk({tag, " c3 rvalid"}, 32'(lsu_rvalid_o), 32'd1);
        chk({tag, " c3 rdata"}, lsu_rdata_o, exp_res);
        chk({tag, " c3 stall"}, 32'(lsu_stall_o), 32'd0);
        ex_mtype_i = 1'b0;
        tick();
        chk({tag, " c4 rvalid"}, 32'(lsu_rvalid_o), 32'd0);
        chk({tag, " c4 rdata hold"}, lsu_rdata_o, exp_res);
    endtask

    // Store with gnt arriving in REQ cycle gnt_dly (1 = immediate).
    task automatic run_store(input string tag, input logic [31:0] addr, input logic [1:0] width,
                             input logic [31:0] wdata, input int gnt_dly,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
        present(1'b0, width, 1'b0, addr, wdata);
        #1;
        chk({tag, " c0 stall"}, 32'(lsu_stall_o), 32'd1);
        for (int i = 1; i <= gnt_dly; i++) begin
            tick();
            chk({tag, " req"}, 32'(dm_bus.req), 32'd1);
            chk({tag, " we"}, 32'(dm_bus.we), 32'd1);
            chk({tag, " addr"}, dm_bus.addr, exp_addr);
            chk({tag, " be"}, 32'(dm_bus.be), 32'(exp_be));
            chk({tag, " wdata"}, dm_bus.wdata, exp_wdata);
            chk({tag, " stall"}, 32'(lsu_stall_o), 32'd1);
            if (i == gnt_dly) dm_bus.gnt = 1'b1;
        end
        tick();
        dm_bus.gnt = 1'b0;
        chk({tag, " done req"}, 32'(dm_bus.req), 32'd0);
        chk({tag, " done stall"}, 32'(lsu_stall_o), 32'd0);
        chk({tag, " done rvalid"}, 32'(lsu_rvalid_o), 32'd0);
        ex_mtype_i = 1'b0;
        tick();
        chk({tag, " idle req"}, 32'(dm_bus.req), 32'd0);
    endtask

    task automatic run_misalign(input string tag, input logic rw, input logic [1:0] width,
                                input logic [31:0] addr);
        present(rw, width, 1'b0, addr, 32'hCAFE_F00D);
        #1;
        chk({tag, " c0 stall"}, 32'(lsu_stall_o), 32'd0);
        tick();
        chk({tag, " c1 misalign"}, 32'(lsu_misalign_o), 32'd1);
        chk({tag, " c1 req"}, 32'(dm_bus.req), 32'd0);
        chk({tag, " c1 stall"}, 32'(lsu_stall_o), 32'd0);
        ex_mtype_i = 1'b0;
        tick();
        chk({tag, " c2 misalign"}, 32'(lsu_misalign_o), 32'd0);
        chk({tag, " c2 req"}, 32'(dm_bus.req), 32'd0);
    endtask

    initial begin
        logic all_req;
        n_chk           = 0;
        n_err           = 0;
        rst_n           = 1'b0;
        ex_mtype_i      = 1'b0;
        ex_mem_rw_i     = 1'b0;
        ex_mem_width_i  = 2'd0;
        ex_mem_rdtype_i = 1'b0;
        ex_addr_i       = 32'h0;
        ex_wdata_i      = 32'h0;
        dm_bus.gnt      = 1'b0;
        dm_bus.rvalid   = 1'b0;
        dm_bus.rdata    = 32'h0;

        tick();
        tick();
        chk("rst req", 32'(dm_bus.req), 32'd0);
        chk("rst stall", 32'(lsu_stall_o), 32'd0);
        chk("rst rvalid", 32'(lsu_rvalid_o), 32'd0);
        chk("rst rdata", lsu_rdata_o, 32'h0);
        chk("rst misalign", 32'(lsu_misalign_o), 32'd0);
        chk("rst err", 32'(lsu_err_o), 32'd0);
        rst_n = 1'b1;
        tick();

        run_load("lw100", 32'h0000_0100, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        run_load("lb103", 32'h0000_0103, 2'd0, 1'b0, 32'h8012_3456, 32'h0000_0100, 4'b1000, 32'hFFFF_FF80);
        run_load("lbu103", 32'h0000_0103, 2'd0, 1'b1, 32'h8012_3456, 32'h0000_0100, 4'b1000, 32'h0000_0080);
        run_load("lh102", 32'h0000_0102, 2'd1, 1'b0, 32'hBEEF_1234, 32'h0000_0100, 4'b1100, 32'hFFFF_BEEF);
        run_load("lhu100", 32'h0000_0100, 2'd1, 1'b1, 32'hBEEF_9234, 32'h0000_0100, 4'b0011, 32'h0000_9234);
        run_load("lb101", 32'h0000_0101, 2'd0, 1'b0, 32'h0000_7F00, 32'h0000_0100, 4'b0010, 32'h0000_007F);

        run_store("sh202", 32'h0000_0202, 2'd1, 32'h1234_ABCD, 3, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
        run_store("sb201", 32'h0000_0201, 2'd0, 32'h0000_0055, 1, 32'h0000_0200, 4'b0010, 32'h5555_5555);
        run_store("sw204", 32'h0000_0204, 2'd2, 32'h0BAD_CAFE, 2, 32'h0000_0204, 4'b1111, 32'h0BAD_CAFE);
        chk("store keeps rdata", lsu_rdata_o, 32'h0000_007F);

        run_misalign("lw102", 1'b1, 2'd2, 32'h0000_0102);
        run_misalign("sh101", 1'b0, 2'd1, 32'h0000_0101);
        run_misalign("w3", 1'b1, 2'd3, 32'h0000_0100);

        // Grant never arrives: 16 REQ cycles, then error pulse in DONE.
        present(1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
        all_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            all_req = all_req & dm_bus.req & ~lsu_err_o;
        end
        chk("to req held 16", 32'(all_req), 32'd1);
        tick();
        chk("to err", 32'(lsu_err_o), 32'd1);
        chk("to req drop", 32'(dm_bus.req), 32'd0);
        chk("to stall", 32'(lsu_stall_o), 32'd0);
        chk("to rvalid", 32'(lsu_rvalid_o), 32'd0);
        ex_mtype_i = 1'b0;
        tick();
        chk("to err pulse", 32'(lsu_err_o), 32'd0);

        // Reset while waiting for read data; a late rvalid must be ignored.
        present(1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'h0);
        tick();
        dm_bus.gnt = 1'b1;
        tick();
        dm_bus.gnt = 1'b0;
        chk("rw wait stall", 32'(lsu_stall_o), 32'd1);
        ex_mtype_i = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("rw rst stall", 32'(lsu_stall_o), 32'd0);
        chk("rw rst req", 32'(dm_bus.req), 32'd0);
        chk("rw rst rdata", lsu_rdata_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        dm_bus.rvalid = 1'b1;
        dm_bus.rdata  = 32'h1357_9BDF;
        tick();
        dm_bus.rvalid = 1'b0;
        chk("rw late rvalid", 32'(lsu_rvalid_o), 32'd0);
        chk("rw late rdata", lsu_rdata_o, 32'h0);
        tick();
        chk("rw late rvalid2", 32'(lsu_rvalid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
